spi_cmd_ram: RTL

// Single-port command-decoded RAM behind the SPI slave, successor to the fixed 8-bit RAM.
// - Decodes 2-bit command + payload words from the SPI receive path; returns read data to the SPI transmit path.
// - Generalised data/address width and depth; adds a valid/ready read handshake, an overrun flag and optional burst auto-increment.

---
 rtl/spi_cmd_ram_if.sv | 23 ++
 rtl/spi_cmd_ram.sv | 113 +++++++++++
 2 files changed

// File: rtl/spi_cmd_ram_if.sv
// Bus between the SPI slave and the command-decoded RAM: receive command words in,
// read data plus status out.
interface spi_cmd_ram_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W+1:0] din;
    logic              rx_valid;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              rd_overrun;

    modport master (
        output din, rx_valid, tx_ready,
        input  dout, tx_valid, busy, rd_overrun
    );

    modport slave (
        input  din, rx_valid, tx_ready,
        output dout, tx_valid, busy, rd_overrun
    );
endinterface

// File: rtl/spi_cmd_ram.sv
// Single-port RAM decoded from 2-bit SPI commands, with a valid/ready read return path.
// Optional burst auto-increment of both addresses when SPI_RAM_AUTO_INC_EN is defined.
module spi_cmd_ram #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input logic          clk,
    input logic          rst_n,
    spi_cmd_ram_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;
    typedef enum logic [1:0] {
        CmdWrAddr = 2'b00,
        CmdWrData = 2'b01,
        CmdRdAddr = 2'b10,
        CmdRdData = 2'b11
    } cmd_e;

    state_e            state_q;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q, fetch_addr_q;
    logic [DATA_W-1:0] dout_q;
    logic              tx_valid_q;
    logic              overrun_q;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    cmd_e              cmd;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] addr;

    assign cmd     = cmd_e'(bus.din[DATA_W+1:DATA_W]);
    assign payload = bus.din[DATA_W-1:0];
    assign addr    = payload[ADDR_W-1:0];

    // Stored addresses are always in range, so writes can never land outside the array.
    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        t = 32'(a) % MEM_DEPTH;
        return t[ADDR_W-1:0];
    endfunction

`ifdef SPI_RAM_AUTO_INC_EN
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MEM_DEPTH - 1);

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LastAddr) ? '0 : a + ADDR_W'(1);
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (bus.rx_valid && cmd == CmdWrData) begin
            mem[wr_addr_q] <= payload;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            fetch_addr_q <= '0;
            dout_q       <= '0;
            tx_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                // fetch_addr_q froze rd_addr at accept; a same-edge write is not yet visible
                StFetch: begin
                    dout_q     <= mem[fetch_addr_q];
                    tx_valid_q <= 1'b1;
                    state_q    <= StHold;
                end
                StHold: begin
                    if (bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (bus.rx_valid) begin
                unique case (cmd)
                    CmdWrAddr: wr_addr_q <= wrap_addr(addr);
`ifdef SPI_RAM_AUTO_INC_EN
                    CmdWrData: wr_addr_q <= next_addr(wr_addr_q);
`else
                    CmdWrData: ;
`endif
                    CmdRdAddr: rd_addr_q <= wrap_addr(addr);
                    CmdRdData: begin
                        if (state_q != StIdle) begin
                            overrun_q <= 1'b1;
                        end else begin
                            state_q      <= StFetch;
                            fetch_addr_q <= rd_addr_q;
`ifdef SPI_RAM_AUTO_INC_EN
                            rd_addr_q    <= next_addr(rd_addr_q);
`endif
                        end
                    end
                endcase
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.rd_overrun = overrun_q;

endmodule
